// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - multi-player tile movement controller with bounds, collision and trail handling
package game_pkg;
  typedef enum logic [2:0] {WAIT = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4} directions;
  typedef enum logic [1:0] {EMPTY = 2'd0, WALL = 2'd1, PLAYER1 = 2'd2, PLAYER2 = 2'd3} tile;
endpackage

module player_move_ctrl
  import game_pkg::*;
#(
  parameter int MAP_W       = 32,
  parameter int MAP_H       = 24,
  parameter int NUM_PLAYERS = 2,
  parameter int WRAP        = 0,
  parameter int TRAIL       = 1,
  parameter int START_X0    = 10,
  parameter int START_Y0    = 18,
  parameter int START_X1    = 21,
  parameter int START_Y1    = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       step,
  input  directions                  direction [NUM_PLAYERS],
  output logic                       ready,
  output logic [$clog2(MAP_W)-1:0]   pos_x [NUM_PLAYERS],
  output logic [$clog2(MAP_H)-1:0]   pos_y [NUM_PLAYERS],
  output logic [NUM_PLAYERS-1:0]     moved,
  output logic [NUM_PLAYERS-1:0]     blocked,
  output tile                        map [MAP_W][MAP_H]
);

  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam logic [XW-1:0] XMAX = XW'(MAP_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(MAP_H - 1);
  localparam logic [XW-1:0] START_X [2] = '{XW'(START_X0), XW'(START_X1)};
  localparam logic [YW-1:0] START_Y [2] = '{YW'(START_Y0), YW'(START_Y1)};
  localparam tile PLAYER_TILE [2] = '{PLAYER1, PLAYER2};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EVAL   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]             state;
  directions              dir_q [NUM_PLAYERS];
  logic [XW-1:0]          tgt_x [NUM_PLAYERS];
  logic [YW-1:0]          tgt_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] go_q;
  logic [NUM_PLAYERS-1:0] act_q;

  logic [XW-1:0]          cand_x [NUM_PLAYERS];
  logic [YW-1:0]          cand_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] act;
  logic [NUM_PLAYERS-1:0] on_map;
  logic [NUM_PLAYERS-1:0] legal;

  assign ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (step) state <= S_EVAL;
        S_EVAL:   state <= S_COMMIT;
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Off-map targets are still given the wrapped cell so the map lookup stays in range.
  always_comb begin
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cand_x[p] = pos_x[p];
      cand_y[p] = pos_y[p];
      act[p]    = (dir_q[p] != WAIT);
      on_map[p] = 1'b1;
      case (dir_q[p])
        UP: begin
          if (pos_y[p] == '0) begin
            on_map[p] = 1'b0;
            cand_y[p] = YMAX;
          end else begin
            cand_y[p] = pos_y[p] - YW'(1);
          end
        end
        DOWN: begin
          if (pos_y[p] == YMAX) begin
            on_map[p] = 1'b0;
            cand_y[p] = '0;
          end else begin
            cand_y[p] = pos_y[p] + YW'(1);
          end
        end
        LEFT: begin
          if (pos_x[p] == '0) begin
            on_map[p] = 1'b0;
            cand_x[p] = XMAX;
          end else begin
            cand_x[p] = pos_x[p] - XW'(1);
          end
        end
        RIGHT: begin
          if (pos_x[p] == XMAX) begin
            on_map[p] = 1'b0;
            cand_x[p] = '0;
          end else begin
            cand_x[p] = pos_x[p] + XW'(1);
          end
        end
        default: ;
      endcase
    end

    for (int p = 0; p < NUM_PLAYERS; p++) begin
      legal[p] = act[p] && (on_map[p] || (WRAP != 0)) &&
                 (map[cand_x[p]][cand_y[p]] == EMPTY);
      for (int q = 0; q < NUM_PLAYERS; q++) begin
        if (q != p && act[q] && (on_map[q] || (WRAP != 0)) &&
            cand_x[q] == cand_x[p] && cand_y[q] == cand_y[p])
          legal[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        dir_q[p] <= WAIT;
        tgt_x[p] <= '0;
        tgt_y[p] <= '0;
        pos_x[p] <= START_X[p];
        pos_y[p] <= START_Y[p];
      end
      go_q    <= '0;
      act_q   <= '0;
      moved   <= '0;
      blocked <= '0;
    end else if (clear) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        dir_q[p] <= WAIT;
        tgt_x[p] <= '0;
        tgt_y[p] <= '0;
        pos_x[p] <= START_X[p];
        pos_y[p] <= START_Y[p];
      end
      go_q    <= '0;
      act_q   <= '0;
      moved   <= '0;
      blocked <= '0;
    end else begin
      moved   <= '0;
      blocked <= '0;
      if (state == S_IDLE && step) begin
        for (int p = 0; p < NUM_PLAYERS; p++) dir_q[p] <= direction[p];
      end
      if (state == S_EVAL) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          tgt_x[p] <= cand_x[p];
          tgt_y[p] <= cand_y[p];
        end
        go_q  <= legal;
        act_q <= act;
      end
      if (state == S_COMMIT) begin
        moved   <= act_q & go_q;
        blocked <= act_q & ~go_q;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (go_q[p]) begin
            pos_x[p] <= tgt_x[p];
            pos_y[p] <= tgt_y[p];
          end
        end
      end
    end
  end

  // One register per cell; positions still hold the source cells during COMMIT.
  for (genvar gx = 0; gx < MAP_W; gx++) begin : g_col
    for (genvar gy = 0; gy < MAP_H; gy++) begin : g_cell
      localparam logic [XW-1:0] CX = XW'(gx);
      localparam logic [YW-1:0] CY = YW'(gy);
      localparam tile INIT =
        (gx == START_X0 && gy == START_Y0) ? PLAYER1 :
        (NUM_PLAYERS > 1 && gx == START_X1 && gy == START_Y1) ? PLAYER2 : EMPTY;

      tile  cell_q;
      tile  cell_d;
      logic cell_wr;

      always_comb begin
        cell_wr = 1'b0;
        cell_d  = EMPTY;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (go_q[p] && tgt_x[p] == CX && tgt_y[p] == CY) begin
            cell_wr = 1'b1;
            cell_d  = PLAYER_TILE[p];
          end else if (go_q[p] && TRAIL == 0 && !cell_wr &&
                       pos_x[p] == CX && pos_y[p] == CY) begin
            cell_wr = 1'b1;
            cell_d  = EMPTY;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cell_q <= INIT;
        end else if (clear) begin
          cell_q <= INIT;
        end else if (state == S_COMMIT && cell_wr) begin
          cell_q <= cell_d;
        end
      end

      assign map[gx][gy] = cell_q;
    end
  end

endmodule
